// File: rtl/game_timebase_ctrl_if.sv
// Button/timer-facing signal bundle for game_timebase_ctrl.
// master = the timebase controller, slave = the button/timer side.
interface game_timebase_ctrl_if #(
   parameter int TIMER_BITS = 6
);
   logic                  start;
   logic                  pause;
   logic                  timer_done;
   logic [TIMER_BITS-1:0] current_time;
   logic                  tick_en;
   logic                  timer_rst_n;
   logic                  running;
   logic                  paused;
   logic                  game_over;
   logic                  warn_blink;

   modport master (
      input  start, pause, timer_done, current_time,
      output tick_en, timer_rst_n, running, paused, game_over, warn_blink
   );

   modport slave (
      output start, pause, timer_done, current_time,
      input  tick_en, timer_rst_n, running, paused, game_over, warn_blink
   );
endinterface

// File: rtl/game_timebase_ctrl.sv
// Game timebase: prescaled tick enable, timer reload and run/pause/expire state,
// plus a low-time warning blink. All outputs are registered from the next state.
module game_timebase_ctrl #(
   parameter int CLKS_PER_TICK = 100_000_000,
   parameter int CNT_BITS      = 27,
   parameter int TIMER_BITS    = 6,
   parameter int WARN_TIME     = 5
) (
   input logic                  clk,
   input logic                  reset,
   game_timebase_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, ARMING, RUNNING, PAUSED, EXPIRED} state_t;

   localparam logic [CNT_BITS-1:0]   PRESC_LAST = CNT_BITS'(CLKS_PER_TICK - 1);
   localparam logic [CNT_BITS-1:0]   PRESC_HALF = CNT_BITS'(CLKS_PER_TICK / 2 - 1);
   localparam logic [TIMER_BITS-1:0] WARN_MAX   = TIMER_BITS'(WARN_TIME);

   state_t              state_reg, state_next;
   logic [CNT_BITS-1:0] presc_reg, presc_next;
   logic                tick_reg, tick_next;
   logic                warn_reg, warn_next;
   logic                timer_rst_n_reg, running_reg, paused_reg, game_over_reg;
   logic                presc_last, presc_half, in_warn, advance;

   assign presc_last = (presc_reg == PRESC_LAST);
   assign presc_half = (presc_reg == PRESC_HALF);
   assign in_warn    = (bus.current_time != '0) && (bus.current_time <= WARN_MAX);

   always_comb begin
      state_next = state_reg;
      advance    = 1'b0;
      case (state_reg)
         IDLE:    if (bus.start) state_next = ARMING;
         ARMING:  state_next = RUNNING;
         RUNNING: begin
            if (bus.timer_done)  state_next = EXPIRED;
            else if (bus.pause)  state_next = PAUSED;
            else                 advance    = 1'b1;
         end
         PAUSED: begin
            if (bus.start) begin
               state_next = ARMING;
            end else if (bus.pause) begin
               // Resume counts as a running cycle, so a prescaler held at its
               // terminal value fires its tick on the first RUNNING cycle.
               state_next = RUNNING;
               advance    = 1'b1;
            end
         end
         EXPIRED: if (bus.start) state_next = ARMING;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      presc_next = presc_reg;
      tick_next  = 1'b0;
      if (state_reg == IDLE || state_reg == ARMING) begin
         presc_next = '0;
      end else if (advance) begin
         presc_next = presc_last ? '0 : presc_reg + CNT_BITS'(1);
         tick_next  = presc_last;
      end
   end

   always_comb begin
      warn_next = 1'b0;
      case (state_next)
         RUNNING: begin
            if (in_warn && state_reg == RUNNING && (presc_last || presc_half))
               warn_next = ~warn_reg;
            else if (in_warn)
               warn_next = warn_reg;
         end
         PAUSED:  warn_next = warn_reg;
         EXPIRED: warn_next = 1'b1;
         default: warn_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         presc_reg       <= '0;
         tick_reg        <= 1'b0;
         warn_reg        <= 1'b0;
         timer_rst_n_reg <= 1'b0;
         running_reg     <= 1'b0;
         paused_reg      <= 1'b0;
         game_over_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         presc_reg       <= presc_next;
         tick_reg        <= tick_next;
         warn_reg        <= warn_next;
         timer_rst_n_reg <= !(state_next == IDLE || state_next == ARMING);
         running_reg     <= (state_next == RUNNING);
         paused_reg      <= (state_next == PAUSED);
         game_over_reg   <= (state_next == EXPIRED);
      end
   end

   assign bus.tick_en     = tick_reg;
   assign bus.timer_rst_n = timer_rst_n_reg;
   assign bus.running     = running_reg;
   assign bus.paused      = paused_reg;
   assign bus.game_over   = game_over_reg;
   assign bus.warn_blink  = warn_reg;
endmodule

// File: tb/tb_game_timebase_ctrl.sv
// Directed bench for game_timebase_ctrl with a 3-second countdown timer model
// attached (CLKS_PER_TICK=4, WARN_TIME=2).
module tb_game_timebase_ctrl;
   localparam int TB_TIMER_BITS = 6;

   logic clk;
   logic reset;
   logic [TB_TIMER_BITS-1:0] tval;
   int tests_run;
   int tests_failed;

   game_timebase_ctrl_if #(.TIMER_BITS(TB_TIMER_BITS)) bus ();

   game_timebase_ctrl #(
      .CLKS_PER_TICK(4),
      .CNT_BITS     (3),
      .TIMER_BITS   (TB_TIMER_BITS),
      .WARN_TIME    (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Countdown timer: reloads to 3 while timer_rst_n is low, decrements on tick_en.
   initial tval = 6'd3;
   always @(posedge clk) begin
      if (!bus.timer_rst_n)                tval <= 6'd3;
      else if (bus.tick_en && tval != '0)  tval <= tval - 6'd1;
   end
   assign bus.current_time = tval;
   assign bus.timer_done   = (tval == '0);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0d", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Steps `first` cycles; tick_en must be high only on the last of them.
   // Any start/pause set by the caller lasts exactly one cycle.
   task automatic expect_tick_at(input int first, input string tag);
      for (int k = 1; k <= first; k++) begin
         step();
         bus.start = 1'b0;
         bus.pause = 1'b0;
         chk($sformatf("%s_tick_c%0d", tag, k), 32'(bus.tick_en), 32'(k == first));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_warn;
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.pause    = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset values
      chk("rst_tick",      32'(bus.tick_en),     0);
      chk("rst_timer_rst", 32'(bus.timer_rst_n), 0);
      chk("rst_running",   32'(bus.running),     0);
      chk("rst_paused",    32'(bus.paused),      0);
      chk("rst_game_over", 32'(bus.game_over),   0);
      chk("rst_warn",      32'(bus.warn_blink),  0);
      reset = 1'b1;
      step();
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      chk("idle_pause_paused",  32'(bus.paused),  0);
      chk("idle_pause_running", 32'(bus.running), 0);

      // Full game: start, three ticks, expiry
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("arm_timer_rst", 32'(bus.timer_rst_n), 0);
      chk("arm_running",   32'(bus.running),     0);
      step();
      chk("run0_running",   32'(bus.running),      1);
      chk("run0_timer_rst", 32'(bus.timer_rst_n),  1);
      chk("run0_time",      32'(bus.current_time), 3);
      for (int k = 1; k <= 16; k++) begin
         step();
         chk($sformatf("g1_tick_c%0d", k), 32'(bus.tick_en), 32'(k == 4 || k == 8 || k == 12));
         chk($sformatf("g1_time_c%0d", k), 32'(bus.current_time),
             (k <= 4) ? 32'd3 : (k <= 8) ? 32'd2 : (k <= 12) ? 32'd1 : 32'd0);
         chk($sformatf("g1_over_c%0d", k), 32'(bus.game_over), 32'(k >= 14));
         chk($sformatf("g1_run_c%0d", k),  32'(bus.running),   32'(k < 14));
         if (k >= 14)                                  exp_warn = 1;
         else if (k == 6 || k == 7 || k == 10 || k == 11) exp_warn = 1;
         else                                          exp_warn = 0;
         chk($sformatf("g1_warn_c%0d", k), 32'(bus.warn_blink), exp_warn);
      end
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      chk("exp_pause_over",   32'(bus.game_over), 1);
      chk("exp_pause_paused", 32'(bus.paused),    0);

      // Restart from EXPIRED; start while RUNNING is ignored
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("rearm_timer_rst", 32'(bus.timer_rst_n), 0);
      chk("rearm_over",      32'(bus.game_over),   0);
      chk("rearm_warn",      32'(bus.warn_blink),  0);
      step();
      chk("restart_time", 32'(bus.current_time), 3);
      bus.start = 1'b1;
      expect_tick_at(4, "g2");
      chk("g2_running", 32'(bus.running), 1);

      // Pause at presc==2, hold 20 cycles, resume keeps phase
      step();
      step();
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      chk("p1_paused",  32'(bus.paused),     1);
      chk("p1_running", 32'(bus.running),    0);
      chk("p1_warn",    32'(bus.warn_blink), 1);
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("p1_hold_tick_c%0d", k), 32'(bus.tick_en), 0);
      end
      chk("p1_warn_held", 32'(bus.warn_blink), 1);
      bus.pause = 1'b1;
      expect_tick_at(2, "p1_resume");

      // Pause coincident with presc terminal
      step();
      step();
      step();
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      chk("p2_tick",   32'(bus.tick_en), 0);
      chk("p2_paused", 32'(bus.paused),  1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("p2_hold_tick_c%0d", k), 32'(bus.tick_en), 0);
      end
      bus.pause = 1'b1;
      expect_tick_at(1, "p2_resume");
      step();
      chk("p2_done", 32'(bus.timer_done), 1);
      step();
      chk("p2_over", 32'(bus.game_over),  1);
      chk("p2_warn", 32'(bus.warn_blink), 1);

      // Restart from PAUSED with start and pause together
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("g3_arm_timer_rst", 32'(bus.timer_rst_n), 0);
      step();
      chk("g3_running", 32'(bus.running), 1);
      step();
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      chk("g3_paused", 32'(bus.paused), 1);
      bus.start = 1'b1;
      bus.pause = 1'b1;
      step();
      bus.start = 1'b0;
      bus.pause = 1'b0;
      chk("g3_rearm_timer_rst", 32'(bus.timer_rst_n), 0);
      chk("g3_rearm_paused",    32'(bus.paused),      0);
      chk("g3_rearm_running",   32'(bus.running),     0);
      step();
      chk("g3_reload_time", 32'(bus.current_time), 3);
      expect_tick_at(4, "g3");

      // Asynchronous reset while tick_en is high
      #2;
      reset = 1'b0;
      #1;
      chk("arst_tick",      32'(bus.tick_en),     0);
      chk("arst_timer_rst", 32'(bus.timer_rst_n), 0);
      chk("arst_running",   32'(bus.running),     0);
      chk("arst_paused",    32'(bus.paused),      0);
      chk("arst_over",      32'(bus.game_over),   0);
      chk("arst_warn",      32'(bus.warn_blink),  0);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("post_rst_running",   32'(bus.running),     0);
      chk("post_rst_timer_rst", 32'(bus.timer_rst_n), 0);
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      chk("post_rst_pause_paused",  32'(bus.paused),  0);
      chk("post_rst_pause_running", 32'(bus.running), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
